// File: rtl/pcie_tlp_pkg.sv
// Shared TLP definitions for the request decoder and completion encoder:
// fmt/type codes, completion status, beat field positions and completion length math.
package pcie_tlp_pkg;

  localparam logic [2:0] FMT_3DW_NODATA = 3'b000;
  localparam logic [2:0] FMT_4DW_NODATA = 3'b001;
  localparam logic [2:0] FMT_3DW_DATA   = 3'b010;
  localparam logic [2:0] FMT_4DW_DATA   = 3'b011;

  localparam logic [4:0] TYPE_MEM = 5'b00000;
  localparam logic [4:0] TYPE_CPL = 5'b01010;

  localparam logic [7:0] FMT_TYPE_MRD  = {FMT_3DW_NODATA, TYPE_MEM};
  localparam logic [7:0] FMT_TYPE_MWR  = {FMT_3DW_DATA, TYPE_MEM};
  localparam logic [7:0] FMT_TYPE_CPL  = {FMT_3DW_NODATA, TYPE_CPL};
  localparam logic [7:0] FMT_TYPE_CPLD = {FMT_3DW_DATA, TYPE_CPL};

  typedef enum logic [2:0] {
    CPL_SC = 3'b000,
    CPL_UR = 3'b001,
    CPL_CA = 3'b100
  } cpl_status_e;

  // DW lsb positions inside the 256-bit beat; [127:0] is always zero.
  localparam int DW0_LSB = 224;
  localparam int DW1_LSB = 192;
  localparam int DW2_LSB = 160;
  localparam int DW3_LSB = 128;

  // Bit positions inside a header DW.
  localparam int FMT_TYPE_LSB  = 24;
  localparam int LENGTH_LSB    = 0;
  localparam int CPL_STATUS_LSB = 13;
  localparam int BYTE_COUNT_LSB = 0;
  localparam int TAG_LSB        = 8;
  localparam int LOWER_ADDR_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT_DATA,
    ST_BUILD,
    ST_BUILD_UR,
    ST_BUILD_CA,
    ST_SEND,
    ST_DONE
  } cpl_enc_state_e;

  typedef struct packed {
    logic [11:0] byte_count;
    logic [6:0]  lower_addr;
  } cpl_len_t;

  // Single-DW request: byte count spans first to last enabled byte; an
  // all-zero enable still reports one byte at offset zero.
  function automatic cpl_len_t cpl_len_calc(input logic [4:0] dw_addr, input logic [3:0] be);
    cpl_len_t   r;
    logic [1:0] lb;
    casez (be)
      4'b1??1: r.byte_count = 12'd4;
      4'b01?1,
      4'b1?10: r.byte_count = 12'd3;
      4'b0011,
      4'b0110,
      4'b1100: r.byte_count = 12'd2;
      default: r.byte_count = 12'd1;
    endcase
    if (be[0] || be == 4'b0000) lb = 2'b00;
    else if (be[1]) lb = 2'b01;
    else if (be[2]) lb = 2'b10;
    else lb = 2'b11;
    r.lower_addr = {dw_addr, lb};
    return r;
  endfunction

endpackage

// File: rtl/pcie_cpl_hdr_build.sv
// Combinational completion builder: captured request fields, status and read
// data in, 3DW header plus one data DW out (DW0 in [127:96]).
module pcie_cpl_hdr_build
  import pcie_tlp_pkg::*;
#(
  parameter logic [15:0] COMPLETER_ID = 16'h0100
) (
  input  logic [4:0]  dw_addr,
  input  logic [3:0]  be,
  input  logic [7:0]  tag,
  input  logic [15:0] requester_id,
  input  cpl_status_e status,
  input  logic [31:0] data,
  output logic [127:0] tlp
);

  cpl_len_t    len;
  logic        with_data;
  logic [31:0] dw0;
  logic [31:0] dw1;
  logic [31:0] dw2;
  logic [31:0] dw3;

  always_comb begin
    len       = cpl_len_calc(dw_addr, be);
    with_data = (status == CPL_SC);
    // Only a successful completion carries data; UR/CA are Cpl with length 0.
    if (with_data) dw0 = {FMT_TYPE_CPLD, 14'd0, 10'd1};
    else dw0 = {FMT_TYPE_CPL, 14'd0, 10'd0};
    dw1 = {COMPLETER_ID, status, 1'b0, len.byte_count};
    dw2 = {requester_id, tag, 1'b0, len.lower_addr};
    dw3 = with_data ? data : 32'h0;
    tlp = {dw0, dw1, dw2, dw3};
  end

endmodule

// File: rtl/pcie_tlp_cpl_enc.sv
// Completion encoder: takes one memory-read request, fetches one DW from local
// memory and sends a single-beat CplD (or UR/CA Cpl) TLP, then pulses cpl_done.
module pcie_tlp_cpl_enc
  import pcie_tlp_pkg::*;
#(
  parameter logic [15:0] COMPLETER_ID = 16'h0100,
  parameter logic [15:0] ADDR_LIMIT   = 16'h4000,
  parameter int          RD_LAT_MAX   = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [15:0]  req_addr,
  input  logic [3:0]   req_be,
  input  logic [7:0]   req_tag,
  input  logic [15:0]  req_requester_id,
  output logic         rd_en,
  output logic [15:0]  rd_addr,
  input  logic [31:0]  rd_data,
  input  logic         rd_valid,
  output logic [255:0] tx_data,
  output logic         tx_valid,
  output logic         tx_sop,
  output logic         tx_eop,
  input  logic         tx_ready,
  output logic         cpl_done
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and tx_data is held while unaccepted.

  localparam int CW = $clog2(RD_LAT_MAX + 1);

  cpl_enc_state_e state, state_next;
  logic [15:2]    addr_q;
  logic [3:0]     be_q;
  logic [7:0]     tag_q;
  logic [15:0]    rid_q;
  logic [31:0]    data_q;
  logic [CW-1:0]  wait_cnt;
  logic [127:0]   beat_q;
  cpl_status_e    status;
  logic [127:0]   tlp;
  logic           timeout;

  pcie_cpl_hdr_build #(
    .COMPLETER_ID(COMPLETER_ID)
  ) u_hdr (
    .dw_addr     (addr_q[6:2]),
    .be          (be_q),
    .tag         (tag_q),
    .requester_id(rid_q),
    .status      (status),
    .data        (data_q),
    .tlp         (tlp)
  );

  // Last waiting cycle is the RD_LAT_MAX-th one spent in WAIT_DATA.
  assign timeout = (wait_cnt == CW'(RD_LAT_MAX - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      addr_q   <= '0;
      be_q     <= '0;
      tag_q    <= '0;
      rid_q    <= '0;
      data_q   <= '0;
      wait_cnt <= '0;
      beat_q   <= '0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && req_valid) begin
        addr_q <= req_addr[15:2];
        be_q   <= req_be;
        tag_q  <= req_tag;
        rid_q  <= req_requester_id;
      end
      if (state == ST_WAIT_DATA && rd_valid) data_q <= rd_data;
      if (state == ST_WAIT_DATA) wait_cnt <= wait_cnt + 1'b1;
      else wait_cnt <= '0;
      if (state == ST_BUILD || state == ST_BUILD_UR || state == ST_BUILD_CA) beat_q <= tlp;
    end
  end

  always_comb begin
    state_next = state;
    status     = CPL_SC;
    case (state)
      ST_IDLE: begin
        if (req_valid) state_next = (req_addr >= ADDR_LIMIT) ? ST_BUILD_UR : ST_FETCH;
      end
      ST_FETCH: state_next = ST_WAIT_DATA;
      ST_WAIT_DATA: begin
        // Data arriving on the timeout cycle still produces a normal CplD.
        if (rd_valid) state_next = ST_BUILD;
        else if (timeout) state_next = ST_BUILD_CA;
      end
      ST_BUILD: state_next = ST_SEND;
      ST_BUILD_UR: begin
        status     = CPL_UR;
        state_next = ST_SEND;
      end
      ST_BUILD_CA: begin
        status     = CPL_CA;
        state_next = ST_SEND;
      end
      ST_SEND: begin
        if (tx_ready) state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == ST_IDLE) && !rst;
    rd_en     = (state == ST_FETCH);
    rd_addr   = (state == ST_FETCH || state == ST_WAIT_DATA) ? {addr_q, 2'b00} : 16'h0;
    tx_valid  = (state == ST_SEND);
    tx_sop    = tx_valid;
    tx_eop    = tx_valid;
    tx_data   = {beat_q, 128'h0};
    cpl_done  = (state == ST_DONE);
  end

endmodule

// File: tb/tb_pcie_tlp_cpl_enc.sv
// Directed bench for pcie_tlp_cpl_enc: CplD, byte-enable length rules, UR,
// CA timeout, data on the timeout cycle, TX back-pressure and mid-send reset.
module tb_pcie_tlp_cpl_enc;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [15:0]  req_addr;
  logic [3:0]   req_be;
  logic [7:0]   req_tag;
  logic [15:0]  req_requester_id;
  logic         rd_en;
  logic [15:0]  rd_addr;
  logic [31:0]  rd_data;
  logic         rd_valid;
  logic [255:0] tx_data;
  logic         tx_valid;
  logic         tx_sop;
  logic         tx_eop;
  logic         tx_ready;
  logic         cpl_done;

  int checks = 0;
  int errors = 0;

  pcie_tlp_cpl_enc dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_addr        (req_addr),
    .req_be          (req_be),
    .req_tag         (req_tag),
    .req_requester_id(req_requester_id),
    .rd_en           (rd_en),
    .rd_addr         (rd_addr),
    .rd_data         (rd_data),
    .rd_valid        (rd_valid),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_sop          (tx_sop),
    .tx_eop          (tx_eop),
    .tx_ready        (tx_ready),
    .cpl_done        (cpl_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents a request in IDLE; returns one cycle after acceptance.
  task automatic issue(input logic [15:0] a, input logic [3:0] b, input logic [7:0] t,
                       input logic [15:0] id);
    req_addr         = a;
    req_be           = b;
    req_tag          = t;
    req_requester_id = id;
    req_valid        = 1'b1;
    chk("req_ready_idle", req_ready, 1'b1);
    step();
    req_valid = 1'b0;
    chk("req_ready_busy", req_ready, 1'b0);
  endtask

  // Called in FETCH; answers lat cycles after rd_en, returns in BUILD.
  task automatic fetch(input logic [15:0] exp_addr, input int lat, input logic [31:0] d);
    chk("rd_en_fetch", rd_en, 1'b1);
    chk("rd_addr_fetch", rd_addr, exp_addr);
    step();
    chk("rd_en_single", rd_en, 1'b0);
    chk("rd_addr_hold", rd_addr, exp_addr);
    repeat (lat - 1) step();
    rd_valid = 1'b1;
    rd_data  = d;
    step();
    rd_valid = 1'b0;
    rd_data  = 32'h0;
  endtask

  // Called in a BUILD state with tx_ready high; returns back in IDLE.
  task automatic send_done(input logic [127:0] exp);
    chk("tx_valid_build", tx_valid, 1'b0);
    step();
    chk("tx_valid_send", tx_valid, 1'b1);
    chk("tx_sop", tx_sop, 1'b1);
    chk("tx_eop", tx_eop, 1'b1);
    chk("tx_data", tx_data, {exp, 128'h0});
    step();
    chk("cpl_done_pulse", cpl_done, 1'b1);
    chk("tx_valid_done", tx_valid, 1'b0);
    step();
    chk("cpl_done_clear", cpl_done, 1'b0);
    chk("req_ready_back", req_ready, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_addr = '0;
    req_be = '0;
    req_tag = '0;
    req_requester_id = '0;
    rd_data = '0;
    rd_valid = 1'b0;
    tx_ready = 1'b1;
    step();
    step();
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_sop", tx_sop, 1'b0);
    chk("rst_tx_eop", tx_eop, 1'b0);
    chk("rst_cpl_done", cpl_done, 1'b0);
    chk("rst_rd_en", rd_en, 1'b0);
    chk("rst_rd_addr", rd_addr, 16'h0);
    chk("rst_tx_data", tx_data, 256'h0);
    chk("rst_req_ready", req_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("req_ready_after_rst", req_ready, 1'b1);

    // Basic CplD, one-cycle read latency
    issue(16'h0010, 4'hF, 8'h05, 16'hABCD);
    fetch(16'h0010, 1, 32'hDEADBEEF);
    send_done({32'h4A000001, 32'h01000004, 32'hABCD0510, 32'hDEADBEEF});

    // be=1000: one byte at offset 3
    issue(16'h0007, 4'b1000, 8'h11, 16'h1234);
    fetch(16'h0004, 1, 32'h11223344);
    send_done({32'h4A000001, 32'h01000001, 32'h12341107, 32'h11223344});

    // be=1010: three bytes from offset 1
    issue(16'h0048, 4'b1010, 8'h66, 16'h0004);
    fetch(16'h0048, 2, 32'h01020304);
    send_done({32'h4A000001, 32'h01000003, 32'h00046649, 32'h01020304});

    // Last in-range address
    issue(16'h3FFF, 4'b0001, 8'h77, 16'h0005);
    fetch(16'h3FFC, 1, 32'h55AA55AA);
    send_done({32'h4A000001, 32'h01000001, 32'h0005777C, 32'h55AA55AA});

    // Unsupported Request: no read strobe, three-cycle turnaround
    issue(16'h4000, 4'hF, 8'h33, 16'h0001);
    chk("ur_no_rd_en", rd_en, 1'b0);
    send_done({32'h0A000000, 32'h01002004, 32'h00013300, 32'h0});

    // Completer Abort after eight silent WAIT_DATA cycles
    issue(16'h0020, 4'hF, 8'h44, 16'h0002);
    chk("ca_rd_en", rd_en, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("ca_waiting", tx_valid, 1'b0);
    end
    step();
    send_done({32'h0A000000, 32'h01008004, 32'h00024420, 32'h0});

    // Data on the timeout cycle wins over the abort
    issue(16'h0104, 4'b0011, 8'h55, 16'h0003);
    fetch(16'h0104, 8, 32'h0BADF00D);
    send_done({32'h4A000001, 32'h01000002, 32'h00035504, 32'h0BADF00D});

    // TX back-pressure for ten cycles with a second request waiting
    issue(16'h0030, 4'hF, 8'h88, 16'h0006);
    fetch(16'h0030, 1, 32'h12345678);
    tx_ready = 1'b0;
    chk("bp_build", tx_valid, 1'b0);
    step();
    req_addr         = 16'h0100;
    req_be           = 4'b1100;
    req_tag          = 8'h99;
    req_requester_id = 16'h0007;
    req_valid        = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_tx_valid", tx_valid, 1'b1);
      chk("bp_tx_data", tx_data, {32'h4A000001, 32'h01000004, 32'h00068830, 32'h12345678, 128'h0});
      chk("bp_req_ready", req_ready, 1'b0);
      step();
    end
    tx_ready = 1'b1;
    chk("bp_still_send", tx_valid, 1'b1);
    step();
    chk("bp_cpl_done", cpl_done, 1'b1);
    chk("bp_req_ready_done", req_ready, 1'b0);
    step();
    chk("bp_req_ready_idle", req_ready, 1'b1);
    step();
    req_valid = 1'b0;
    fetch(16'h0100, 1, 32'h9ABCDEF0);
    send_done({32'h4A000001, 32'h01000002, 32'h00079902, 32'h9ABCDEF0});

    // Reset while the beat is waiting in SEND
    issue(16'h0008, 4'hF, 8'hAA, 16'h0008);
    fetch(16'h0008, 1, 32'hFFFF0000);
    tx_ready = 1'b0;
    step();
    chk("rst_mid_send", tx_valid, 1'b1);
    rst = 1'b1;
    step();
    chk("rst_mid_tx_valid", tx_valid, 1'b0);
    chk("rst_mid_cpl_done", cpl_done, 1'b0);
    chk("rst_mid_tx_data", tx_data, 256'h0);
    rst = 1'b0;
    tx_ready = 1'b1;
    #1;
    chk("rst_mid_req_ready", req_ready, 1'b1);

    // Normal completion after the reset: be=0110
    issue(16'h0004, 4'b0110, 8'h22, 16'h5678);
    fetch(16'h0004, 1, 32'hCAFEF00D);
    send_done({32'h4A000001, 32'h01000002, 32'h56782205, 32'hCAFEF00D});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
